// File: rtl/shader_load_stager_if.sv
// Handshake and memory-side bundle for the shader load stager.
// The master side supplies instructions and frame/cancel events; the
// slave side is the stager, which returns the memory stream and status.
interface shader_load_stager_if #(
  parameter int NUM_INSTR = 12,
  parameter int INSTR_W   = 8
);
  localparam int FILL_W = $clog2(NUM_INSTR + 1);

  logic [INSTR_W-1:0] wr_instr_i;
  logic               wr_valid_i;
  logic               wr_ready_o;
  logic               cancel_i;
  logic               frame_i;
  logic [INSTR_W-1:0] mem_instr_o;
  logic               mem_load_o;
  logic [FILL_W-1:0]  fill_level_o;
  logic               pending_o;
  logic               done_o;
  logic               overflow_o;

  modport master (
    output wr_instr_i, wr_valid_i, cancel_i, frame_i,
    input  wr_ready_o, mem_instr_o, mem_load_o, fill_level_o,
           pending_o, done_o, overflow_o
  );

  modport slave (
    input  wr_instr_i, wr_valid_i, cancel_i, frame_i,
    output wr_ready_o, mem_instr_o, mem_load_o, fill_level_o,
           pending_o, done_o, overflow_o
  );
endinterface

// File: rtl/shader_load_stager.sv
// Shader load stager: collects a full program from the SPI instruction
// stream, holds it until a frame boundary, then writes it to shader
// memory as one uninterrupted burst so a program is never half-loaded
// while a frame is being drawn.
module shader_load_stager #(
  parameter int NUM_INSTR = 12,
  parameter int INSTR_W   = 8
) (
  input logic             clk_i,
  input logic             rst_ni,
  shader_load_stager_if.slave bus
);
  localparam int FILL_W = $clog2(NUM_INSTR + 1);
  localparam logic [FILL_W-1:0] LAST = FILL_W'(NUM_INSTR - 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(NUM_INSTR);

  typedef enum logic [1:0] {FILL, PENDING, COMMIT} state_t;

  state_t             state;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  rd_idx;
  logic [INSTR_W-1:0] mem_instr;
  logic               mem_load;
  logic               pending;
  logic               done;
  logic               overflow;
  logic               accept;
  logic [INSTR_W-1:0] prog_buf [NUM_INSTR];

  // Writes are only taken while filling; a cancel in the same cycle drops the write.
  assign accept         = bus.wr_valid_i && (state == FILL) && !bus.cancel_i;
  assign bus.wr_ready_o = (state == FILL);
  assign bus.mem_instr_o  = mem_instr;
  assign bus.mem_load_o   = mem_load;
  assign bus.fill_level_o = fill;
  assign bus.pending_o    = pending;
  assign bus.done_o       = done;
  assign bus.overflow_o   = overflow;

  // Program storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      prog_buf[fill] <= bus.wr_instr_i;
    end
  end

  // Control FSM with registered outputs; the first load is issued on the
  // frame edge itself so the burst starts the cycle after frame_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= FILL;
      fill      <= '0;
      rd_idx    <= '0;
      mem_instr <= '0;
      mem_load  <= 1'b0;
      pending   <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        FILL: begin
          if (bus.cancel_i) begin
            fill     <= '0;
            overflow <= 1'b0;
          end else if (bus.wr_valid_i) begin
            fill <= fill + 1'b1;
            if (fill == LAST) begin
              state   <= PENDING;
              pending <= 1'b1;
            end
          end
        end
        PENDING: begin
          if (bus.cancel_i) begin
            state    <= FILL;
            fill     <= '0;
            pending  <= 1'b0;
            overflow <= 1'b0;
          end else begin
            if (bus.wr_valid_i) begin
              overflow <= 1'b1;
            end
            if (bus.frame_i) begin
              state     <= COMMIT;
              pending   <= 1'b0;
              mem_load  <= 1'b1;
              mem_instr <= prog_buf[0];
              rd_idx    <= FILL_W'(1);
            end
          end
        end
        COMMIT: begin
          if (bus.wr_valid_i) begin
            overflow <= 1'b1;
          end
          if (rd_idx == FULL) begin
            state    <= FILL;
            fill     <= '0;
            rd_idx   <= '0;
            mem_load <= 1'b0;
            done     <= 1'b1;
          end else begin
            mem_instr <= prog_buf[rd_idx];
            rd_idx    <= rd_idx + 1'b1;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shader_load_stager.sv
// Testbench for shader_load_stager: a fixed vector table for the basic
// fill/commit timeline, hand-written corner sequences, and a randomized
// run, all compared cycle by cycle against a queue-based reference model.
module tb_shader_load_stager;
  localparam int N = 12;
  localparam int W = 8;

  logic clk;
  logic rst_ni;
  int   errors = 0;
  int   checks = 0;

  shader_load_stager_if #(.NUM_INSTR(N), .INSTR_W(W)) bus ();

  shader_load_stager #(.NUM_INSTR(N), .INSTR_W(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: staged program, remaining burst, and status flags.
  logic [W-1:0] m_staged [$];
  logic [W-1:0] m_burst  [$];
  bit           m_commit;
  bit           m_load;
  bit           m_done;
  bit           m_ov;
  logic [W-1:0] m_instr;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         c;
    logic         f;
    logic         e_ready;
    logic         e_load;
    logic [W-1:0] e_instr;
    logic [3:0]   e_fill;
    logic         e_pend;
    logic         e_done;
    logic         e_ov;
  } vec_t;

  vec_t tbl [27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_staged.delete();
    m_burst.delete();
    m_commit = 0;
    m_load   = 0;
    m_done   = 0;
    m_ov     = 0;
    m_instr  = '0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] d, input logic c, input logic f);
    m_done = 0;
    if (m_commit) begin
      if (v) m_ov = 1;
      if (m_burst.size() > 0) begin
        m_instr = m_burst.pop_front();
      end else begin
        m_commit = 0;
        m_load   = 0;
        m_done   = 1;
        m_staged.delete();
      end
    end else if (m_staged.size() == N) begin
      if (c) begin
        m_staged.delete();
        m_ov = 0;
      end else begin
        if (v) m_ov = 1;
        if (f) begin
          m_burst  = m_staged;
          m_commit = 1;
          m_load   = 1;
          m_instr  = m_burst.pop_front();
        end
      end
    end else begin
      if (c) begin
        m_staged.delete();
        m_ov = 0;
      end else if (v) begin
        m_staged.push_back(d);
      end
    end
  endtask

  task automatic check_model();
    int fill_exp;
    fill_exp = m_commit ? N : m_staged.size();
    check("ready",   32'(bus.wr_ready_o),   32'(!m_commit && m_staged.size() < N));
    check("load",    32'(bus.mem_load_o),   32'(m_load));
    check("instr",   32'(bus.mem_instr_o),  32'(m_instr));
    check("fill",    32'(bus.fill_level_o), 32'(fill_exp));
    check("pending", 32'(bus.pending_o),    32'(!m_commit && m_staged.size() == N));
    check("done",    32'(bus.done_o),       32'(m_done));
    check("overflow",32'(bus.overflow_o),   32'(m_ov));
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic c, input logic f);
    bus.wr_valid_i = v;
    bus.wr_instr_i = d;
    bus.cancel_i   = c;
    bus.frame_i    = f;
    @(posedge clk);
    #1;
    model_step(v, d, c, f);
    check_model();
    bus.wr_valid_i = 1'b0;
    bus.cancel_i   = 1'b0;
    bus.frame_i    = 1'b0;
  endtask

  task automatic load_program(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) cycle(1'b1, base + W'(i), 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] got [$];
    int loads;

    // Basic timeline: 12 writes, idle, frame, 12 loads, done.
    for (int i = 0; i < 27; i++) begin
      tbl[i] = '{v:1'b0, d:'0, c:1'b0, f:1'b0, e_ready:1'b0, e_load:1'b0,
                 e_instr:'0, e_fill:4'd12, e_pend:1'b0, e_done:1'b0, e_ov:1'b0};
    end
    for (int i = 0; i < N; i++) begin
      tbl[i].v       = 1'b1;
      tbl[i].d       = W'(i + 1);
      tbl[i].e_ready = (i < N - 1);
      tbl[i].e_fill  = 4'(i + 1);
      tbl[i].e_pend  = (i == N - 1);
    end
    tbl[12].e_pend = 1'b1;
    tbl[13].f      = 1'b1;
    for (int k = 0; k < N; k++) begin
      tbl[13 + k].e_load  = 1'b1;
      tbl[13 + k].e_instr = W'(k + 1);
    end
    tbl[25].e_instr = 8'h0C;
    tbl[25].e_done  = 1'b1;
    tbl[25].e_ready = 1'b1;
    tbl[25].e_fill  = 4'd0;
    tbl[26].e_instr = 8'h0C;
    tbl[26].e_ready = 1'b1;
    tbl[26].e_fill  = 4'd0;

    bus.wr_valid_i = 1'b0;
    bus.wr_instr_i = '0;
    bus.cancel_i   = 1'b0;
    bus.frame_i    = 1'b0;
    rst_ni = 1'b0;
    model_reset();
    #12;
    check("rst_ready",   32'(bus.wr_ready_o),   32'd1);
    check("rst_load",    32'(bus.mem_load_o),   32'd0);
    check("rst_instr",   32'(bus.mem_instr_o),  32'd0);
    check("rst_fill",    32'(bus.fill_level_o), 32'd0);
    check("rst_pending", 32'(bus.pending_o),    32'd0);
    check("rst_done",    32'(bus.done_o),       32'd0);
    check("rst_ov",      32'(bus.overflow_o),   32'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < 27; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].f);
      check("tbl_ready",   32'(bus.wr_ready_o),   32'(tbl[i].e_ready));
      check("tbl_load",    32'(bus.mem_load_o),   32'(tbl[i].e_load));
      check("tbl_instr",   32'(bus.mem_instr_o),  32'(tbl[i].e_instr));
      check("tbl_fill",    32'(bus.fill_level_o), 32'(tbl[i].e_fill));
      check("tbl_pending", 32'(bus.pending_o),    32'(tbl[i].e_pend));
      check("tbl_done",    32'(bus.done_o),       32'(tbl[i].e_done));
      check("tbl_ov",      32'(bus.overflow_o),   32'(tbl[i].e_ov));
    end

    // Partial program: frame ignored, then completed and committed.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h21 + W'(i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("partial_noload", 32'(bus.mem_load_o),   32'd0);
    check("partial_fill",   32'(bus.fill_level_o), 32'd5);
    for (int i = 5; i < N; i++) cycle(1'b1, 8'h21 + W'(i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("partial_first", 32'(bus.mem_instr_o), 32'h21);
    for (int i = 1; i < N; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    check("partial_last", 32'(bus.mem_instr_o), 32'h2C);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("partial_done", 32'(bus.done_o), 32'd1);

    // Overflow in PENDING: sticky, data dropped, cleared by cancel.
    load_program(8'h31);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ov_set", 32'(bus.overflow_o), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("ov_sticky", 32'(bus.overflow_o), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    got.delete();
    for (int i = 0; i < N; i++) begin
      if (bus.mem_load_o) got.push_back(bus.mem_instr_o);
      cycle(1'b0, '0, 1'b0, 1'b0);
    end
    check("ov_burst_len", 32'(got.size()), 32'(N));
    for (int i = 0; i < got.size(); i++) check("ov_burst_data", 32'(got[i]), 32'h31 + 32'(i));
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("ov_cleared", 32'(bus.overflow_o), 32'd0);

    // Cancel and frame together in PENDING: no burst.
    load_program(8'h41);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("cxl_fill", 32'(bus.fill_level_o), 32'd0);
    loads = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      loads += int'(bus.mem_load_o);
    end
    check("cxl_noload", 32'(loads), 32'd0);

    // Cancel during COMMIT is ignored.
    load_program(8'h51);
    cycle(1'b0, '0, 1'b0, 1'b1);
    loads = 1;
    for (int i = 1; i < N + 1; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b1);
      loads += int'(bus.mem_load_o);
    end
    check("commit_cxl_loads", 32'(loads), 32'(N));

    // Reset on the 4th load cycle aborts the burst immediately.
    load_program(8'h61);
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    check("pre_rst_instr", 32'(bus.mem_instr_o), 32'h64);
    rst_ni = 1'b0;
    #1;
    model_reset();
    check("arst_load",  32'(bus.mem_load_o),   32'd0);
    check("arst_ready", 32'(bus.wr_ready_o),   32'd1);
    check("arst_fill",  32'(bus.fill_level_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    load_program(8'h71);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("fresh_first", 32'(bus.mem_instr_o), 32'h71);
    for (int i = 0; i < N + 1; i++) cycle(1'b0, '0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 99) < 8));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shader_load_stager.md
Name: shader_load_stager

Overview:
- Staging buffer between the SPI receiver's instruction stream and the shader instruction memory.
- Collects a complete program of NUM_INSTR instructions.
- Holds the program until the next frame boundary, then writes it into shader memory as one atomic burst.
- The shader therefore never executes a partially loaded program mid-frame (no tearing).

Parameters:
- NUM_INSTR, 12, number of instructions in one shader program (buffer depth, burst length).
- INSTR_W, 8, instruction width in bits.

Ports:
- clk_i  input  1  pixel clock.
- rst_ni  input  1  asynchronous active-low reset.
- wr_instr_i  input  INSTR_W  instruction from the SPI receiver.
- wr_valid_i  input  1  wr_instr_i is valid this cycle.
- wr_ready_o  output  1  stager accepts a write this cycle.
- cancel_i  input  1  discard the partially or fully staged program.
- frame_i  input  1  one-cycle frame-boundary pulse (vertical timing next).
- mem_instr_o  output  INSTR_W  instruction to shader memory.
- mem_load_o  output  1  load strobe to shader memory; one instruction per asserted cycle.
- fill_level_o  output  $clog2(NUM_INSTR+1)  number of staged instructions.
- pending_o  output  1  full program staged, waiting for frame_i.
- done_o  output  1  one-cycle pulse after a burst completes.
- overflow_o  output  1  sticky: a write was attempted while not ready.

Behaviour:
- Reset (asynchronous, rst_ni low), all values apply immediately:
  - State FILL, fill count 0, read index 0.
  - wr_ready_o=1; mem_load_o=0; mem_instr_o=0; pending_o=0; done_o=0; overflow_o=0.
  - Buffer contents need no reset.
- The FSM has three states: FILL, PENDING, COMMIT. All outputs are registered except wr_ready_o, which is decoded from state (1 only in FILL).
- FILL:
  - A write is accepted when wr_valid_i and wr_ready_o are both 1. The instruction goes to buf[fill] and fill increments.
  - If the accepted write is the NUM_INSTR-th (fill==NUM_INSTR-1), go to PENDING on the next cycle; fill_level_o becomes NUM_INSTR.
  - frame_i is ignored (a partial program is never committed).
- PENDING:
  - pending_o=1 and wr_ready_o=0.
  - wr_valid_i=1 sets overflow_o; the data is dropped.
  - frame_i=1 moves to COMMIT with read index 0.
- COMMIT:
  - For exactly NUM_INSTR consecutive cycles: mem_load_o=1 and mem_instr_o=buf[k], for k=0..NUM_INSTR-1 in order.
  - After the last load: go to FILL, fill=0, done_o=1 for one cycle, mem_load_o=0. mem_instr_o holds its last value.
  - wr_valid_i sets overflow_o, as in PENDING.
- Latency: frame_i high at cycle t gives mem_load_o high at cycles t+1..t+NUM_INSTR. At cycle t+NUM_INSTR+1: done_o=1 and wr_ready_o=1.
- cancel_i:
  - In FILL or PENDING: go to FILL, fill=0, pending_o=0, overflow_o=0.
  - Ignored in COMMIT; the burst is atomic.
- Simultaneous events:
  - cancel_i with an accepted write in FILL: cancel wins and the write is dropped.
  - cancel_i with frame_i in PENDING: cancel wins and no burst occurs.
  - frame_i during COMMIT: ignored.
- Counters never wrap. fill saturates at NUM_INSTR by construction, because writes are blocked outside FILL.
- Reset mid-COMMIT: the burst aborts immediately and mem_load_o=0 asynchronously. Shader memory is left partially loaded (accepted).
- A back-to-back program can begin filling in the cycle done_o is high.

Test Plan:
- Reset, write 12 instructions 0x01..0x0C with wr_valid_i held high → wr_ready_o drops after the 12th accept, pending_o=1, fill_level_o=12, mem_load_o stays 0.
- From PENDING, pulse frame_i at cycle t → mem_load_o=1 at t+1..t+12 with mem_instr_o=0x01..0x0C in order; done_o=1 and wr_ready_o=1 at t+13; fill_level_o=0.
- Write 5 instructions, then pulse frame_i → no mem_load_o, fill_level_o stays 5; write 7 more, pulse frame_i → burst of 12 starting with the first of the 5.
- In PENDING, assert wr_valid_i with 0xFF → overflow_o=1 and stays 1; the burst still emits the original 12; cancel_i clears overflow_o.
- Assert cancel_i and frame_i in the same PENDING cycle → state FILL, fill_level_o=0, no load strobes. Assert cancel_i during COMMIT → all 12 loads still occur.
- Assert rst_ni low at the 4th load cycle of COMMIT → mem_load_o=0 immediately; after release wr_ready_o=1, fill_level_o=0, and a fresh 12-write program commits correctly.
